// File: rtl/qcv_lsu_if.sv
// Data-memory bus between the LSU (master) and memory (slave).
// Handshake: a request is held with stable address/be/we/wdata until req&gnt; exactly one rvalid (with rdata/err) follows a later cycle.
interface qcv_lsu_if;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;

    modport master (
        output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
    );
    modport slave (
        input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
    );
endinterface

// File: rtl/qcv_lsu.sv
// Load/store unit: one outstanding bus access, byte/half/word with lane steering and extension.
// Define QCV_LSU_MISALIGNED_EN to split misaligned accesses into two word transactions; otherwise they error.
module qcv_lsu (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [1:0]        lsu_type_i,
    input  logic              lsu_sign_ext_i,
    input  logic [31:0]       lsu_addr_i,
    input  logic [31:0]       lsu_wdata_i,
    output logic [31:0]       lsu_rdata_o,
    output logic              lsu_done_o,
    output logic              lsu_err_o,
    output logic              lsu_busy_o,
    qcv_lsu_if.master         bus,
    output logic [2:0]        dbg_state_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ1  = 3'd1;
    localparam logic [2:0] S_RESP1 = 3'd2;
    localparam logic [2:0] S_REQ2  = 3'd3;
    localparam logic [2:0] S_RESP2 = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        req_q, we_q, sign_q, split_q, bad_q, done_q, err_q;
    logic [1:0]  off_q, type_q;
    logic [3:0]  be_q, be2_q;
    logic [31:0] addr_q, wdata_q, rdata1_q, rdata_q;

    logic [3:0]  mask_w;
    logic [7:0]  be64_w;
    logic        split_w, bad_w;
    logic [31:0] wrot_w, lo_w, hi_w, shifted_w, ext_w;

    always_comb begin
        mask_w = 4'b1111;
        case (lsu_type_i)
            2'b00:   mask_w = 4'b0001;
            2'b01:   mask_w = 4'b0011;
            default: mask_w = 4'b1111;
        endcase
    end

    assign be64_w  = {4'b0000, mask_w} << lsu_addr_i[1:0];
    assign split_w = |be64_w[7:4];
`ifdef QCV_LSU_MISALIGNED_EN
    assign bad_w   = (lsu_type_i == 2'b11);
`else
    assign bad_w   = (lsu_type_i == 2'b11) || split_w;
`endif

    // Rotate left by 8*off: shifting {w,w} right by 32-8*off leaves the rotated word in the low half.
    assign wrot_w = 32'({lsu_wdata_i, lsu_wdata_i} >> (6'd32 - {1'b0, lsu_addr_i[1:0], 3'b000}));

    assign lo_w      = split_q ? rdata1_q : bus.data_rdata_i;
    assign hi_w      = split_q ? bus.data_rdata_i : 32'd0;
    assign shifted_w = 32'({hi_w, lo_w} >> {off_q, 3'b000});

    always_comb begin
        ext_w = shifted_w;
        case (type_q)
            2'b00:   ext_w = {{24{sign_q & shifted_w[7]}}, shifted_w[7:0]};
            2'b01:   ext_w = {{16{sign_q & shifted_w[15]}}, shifted_w[15:0]};
            default: ext_w = shifted_w;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (lsu_req_i) state_d = S_REQ1;
            S_REQ1:  if (bad_q) state_d = S_IDLE;
                     else if (req_q && bus.data_gnt_i) state_d = S_RESP1;
            S_RESP1: if (bus.data_rvalid_i)
                         state_d = (!bus.data_err_i && split_q) ? S_REQ2 : S_IDLE;
            S_REQ2:  if (req_q && bus.data_gnt_i) state_d = S_RESP2;
            S_RESP2: if (bus.data_rvalid_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            sign_q   <= 1'b0;
            split_q  <= 1'b0;
            bad_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            off_q    <= 2'b00;
            type_q   <= 2'b00;
            be_q     <= 4'b0000;
            be2_q    <= 4'b0000;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata1_q <= 32'd0;
            rdata_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: if (lsu_req_i) begin
                    addr_q  <= {lsu_addr_i[31:2], 2'b00};
                    be_q    <= be64_w[3:0];
                    be2_q   <= be64_w[7:4];
                    we_q    <= lsu_we_i;
                    wdata_q <= wrot_w;
                    off_q   <= lsu_addr_i[1:0];
                    type_q  <= lsu_type_i;
                    sign_q  <= lsu_sign_ext_i;
                    split_q <= split_w;
                    bad_q   <= bad_w;
                    req_q   <= !bad_w;
                end
                S_REQ1: begin
                    if (bad_q) err_q <= 1'b1;
                    else if (bus.data_gnt_i) req_q <= 1'b0;
                end
                S_RESP1: if (bus.data_rvalid_i) begin
                    if (bus.data_err_i) begin
                        err_q <= 1'b1;
                    end else if (split_q) begin
                        req_q    <= 1'b1;
                        addr_q   <= addr_q + 32'd4;
                        be_q     <= be2_q;
                        rdata1_q <= bus.data_rdata_i;
                    end else begin
                        done_q <= 1'b1;
                        if (!we_q) rdata_q <= ext_w;
                    end
                end
                S_REQ2: if (bus.data_gnt_i) req_q <= 1'b0;
                S_RESP2: if (bus.data_rvalid_i) begin
                    if (bus.data_err_i) begin
                        err_q <= 1'b1;
                    end else begin
                        done_q <= 1'b1;
                        if (!we_q) rdata_q <= ext_w;
                    end
                end
                default: ;
            endcase
        end
    end

    assign lsu_rdata_o      = rdata_q;
    assign lsu_done_o       = done_q;
    assign lsu_err_o        = err_q;
    assign lsu_busy_o       = (state_q != S_IDLE);
    assign bus.data_req_o   = req_q;
    assign bus.data_addr_o  = addr_q;
    assign bus.data_we_o    = we_q;
    assign bus.data_be_o    = be_q;
    assign bus.data_wdata_o = wdata_q;
    assign dbg_state_o      = state_q;
endmodule

// File: doc/qcv_lsu.md
QCV_LSU -- requirements
Module: qcv_lsu

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit address/data.
REQ-002 clk_i  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 lsu_req_i  input  1  EX request valid; sampled only while lsu_busy_o=0.
REQ-005 lsu_we_i  input  1  1=store, 0=load.
REQ-006 lsu_type_i  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-007 lsu_sign_ext_i  input  1  load sign-extend (LB/LH) vs zero-extend (LBU/LHU).
REQ-008 lsu_addr_i  input  32  byte address, driven from the ALU adder result.
REQ-009 lsu_wdata_i  input  32  store data, right-aligned.
REQ-010 lsu_rdata_o  output  32  extended load result; valid when lsu_done_o=1 and load.
REQ-011 lsu_done_o  output  1  one-cycle completion pulse, loads and stores.
REQ-012 lsu_err_o  output  1  one-cycle error pulse; mutually exclusive with lsu_done_o.
REQ-013 lsu_busy_o  output  1  high from the cycle after acceptance until the done/err cycle, exclusive.
REQ-014 data_req_o  output  1  bus request; held until data_gnt_i.
REQ-015 data_gnt_i  input  1  bus grant; the request transfers in the cycle req&gnt.
REQ-016 data_addr_o  output  32  word-aligned address (bits[1:0]=00).
REQ-017 data_we_o  output  1  bus write enable.
REQ-018 data_be_o  output  4  byte enables.
REQ-019 data_wdata_o  output  32  lane-aligned store data.
REQ-020 data_rvalid_i  input  1  response for the granted transaction; loads and stores, earliest one cycle after grant.
REQ-021 data_rdata_i  input  32  load data; valid with data_rvalid_i.
REQ-022 data_err_i  input  1  bus error; valid with data_rvalid_i.

Function
REQ-023 FSM states SHALL be IDLE, REQ1, RESP1, REQ2, RESP2; one transaction outstanding max.
REQ-024 In IDLE with lsu_req_i=1, all lsu_* inputs SHALL be registered and the FSM SHALL go to REQ1; data_req_o is registered, first high the next cycle.
REQ-025 REQx->RESPx on data_gnt_i; data_addr_o/be/we/wdata SHALL stay stable while data_req_o=1 and not granted.
REQ-026 RESP1->IDLE on rvalid (aligned or error); RESP1->REQ2 on rvalid without error for a split access; RESP2->IDLE on rvalid.
REQ-027 off=addr[1:0], mask=0001/0011/1111 for byte/half/word; 8-bit be64=mask<<off; first be=be64[3:0], second be=be64[7:4].
REQ-028 Access is misaligned iff be64[7:4]!=0, i.e. half at off=3, word at off!=0.
REQ-029 data_wdata_o SHALL be lsu_wdata rotated left by 8*off for both transactions.
REQ-030 Second transaction address SHALL be {addr[31:2],2'b00}+4, wrapping modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-031 Load result SHALL be ({rdata2,rdata1}>>8*off)[31:0] (rdata2=0 if aligned), then bits above 8/16 sign- or zero-extended per lsu_sign_ext_i.
REQ-032 lsu_done_o/lsu_rdata_o SHALL be registered: asserted the cycle after the final rvalid; aligned best case request cycle 0 -> done in cycle 3.
REQ-033 data_err_i SHALL end the access: lsu_err_o pulse the cycle after, no second transaction, lsu_rdata_o unchanged.
REQ-034 lsu_type_i=11 SHALL produce lsu_err_o two cycles after acceptance with no bus request.
REQ-035 data_rvalid_i and data_gnt_i SHALL be ignored in IDLE.

Reset
REQ-036 rst_i SHALL force IDLE; lsu_rdata_o=0, and lsu_done_o, lsu_err_o, lsu_busy_o, data_req_o, data_we_o=0, data_be_o=0.
REQ-037 Reset mid-access SHALL drop the access without done/err; late rvalid after reset is ignored.

Configuration
REQ-038 With QCV_LSU_MISALIGNED_EN defined, misaligned accesses SHALL split per REQ-026..031; without it, a misaligned access SHALL produce lsu_err_o with no bus request, same timing as REQ-034.

Verification
REQ-039 LW addr 0x100, gnt and rvalid immediate, rdata 0xDEADBEEF -> data_addr 0x100, be 1111, done cycle 3, rdata_o 0xDEADBEEF.
REQ-040 LB sign addr 0x203, rdata 0x80000000 -> be 1000, rdata_o 0xFFFFFF80; LBU -> 0x00000080.
REQ-041 SH addr 0x302, wdata 0x0000ABCD, gnt delayed 3 cycles -> be 1100, wdata 0xABCD0000, outputs stable until gnt.
REQ-042 MISALIGNED_EN: LW addr 0xFFFFFFFD, rdata1 0x11223344, rdata2 0x55667788 -> addrs 0xFFFFFFFC/0x00000000, be 1110/0001, rdata_o 0x88112233.
REQ-043 Split SW with data_err_i on first rvalid -> lsu_err_o pulse, no second data_req_o; without macro -> lsu_err_o, data_req_o never high.
REQ-044 rst_i asserted in RESP1, then rvalid arrives -> no done/err, busy 0, next request serviced normally.
